// File: rtl/logic16_arbiter.sv
// Round-robin arbiter sharing one 16-bit logic unit (NOT/AND/OR/MUX) among NREQ
// requesters; one grant per cycle, result registered with the requester ID.

module logic16_lu #(
  parameter int W = 16
) (
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [W-1:0] y
);
  always_comb begin
    y = '0;
    unique case (op)
      2'b00: y = ~a;
      2'b01: y = a & b;
      2'b10: y = a | b;
      2'b11: y = sel ? b : a;
    endcase
  end
endmodule

// Per-requester operand gate: only the granted lane drives the shared OR bus.
module logic16_arb_lane #(
  parameter int W = 16
) (
  input  logic         gnt,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sel,
  output logic [1:0]   op_g,
  output logic [W-1:0] a_g,
  output logic [W-1:0] b_g,
  output logic         sel_g
);
  assign op_g  = gnt ? op  : '0;
  assign a_g   = gnt ? a   : '0;
  assign b_g   = gnt ? b   : '0;
  assign sel_g = gnt & sel;
endmodule

module logic16_arbiter #(
  parameter int NREQ = 4,
  parameter int W    = 16,
  parameter int ID_W = 2
) (
  input  logic                 in_clk,
  input  logic                 in_rst_n,
  input  logic [NREQ-1:0]      in_req_valid,
  output logic [NREQ-1:0]      out_req_ready,
  input  logic [2*NREQ-1:0]    in_req_op,
  input  logic [W*NREQ-1:0]    in_req_a,
  input  logic [W*NREQ-1:0]    in_req_b,
  input  logic [NREQ-1:0]      in_req_sel,
  output logic                 out_rsp_valid,
  input  logic                 in_rsp_ready,
  output logic [W-1:0]         out_rsp_y,
  output logic [ID_W-1:0]      out_rsp_id,
  output logic [15:0]          out_count
);
  typedef enum logic {IDLE, FULL} state_t;

  state_t              state, state_nxt;
  logic [ID_W-1:0]     last_grant, win_id;
  logic [NREQ-1:0]     gnt;
  logic                any_vld, can_accept, req_xfer, rsp_xfer;
  logic [NREQ-1:0][1:0]   op_g;
  logic [NREQ-1:0][W-1:0] a_g, b_g;
  logic [NREQ-1:0]        sel_g;
  logic [1:0]          op_m;
  logic [W-1:0]        a_m, b_m, lu_y;
  logic                sel_m;

  // Scan from the lane after last_grant, wrapping; first valid lane wins.
  always_comb begin
    logic [ID_W:0] s;
    logic          found;
    gnt    = '0;
    win_id = '0;
    found  = 1'b0;
    s      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      s = {1'b0, last_grant} + (ID_W+1)'(k);
      if (s >= (ID_W+1)'(NREQ)) s = s - (ID_W+1)'(NREQ);
      if (!found && in_req_valid[s[ID_W-1:0]]) begin
        found               = 1'b1;
        gnt[s[ID_W-1:0]]    = 1'b1;
        win_id              = s[ID_W-1:0];
      end
    end
  end

  assign any_vld       = |in_req_valid;
  assign can_accept    = (state == IDLE) | in_rsp_ready;
  assign req_xfer      = in_rst_n & can_accept & any_vld;
  assign rsp_xfer      = (state == FULL) & in_rsp_ready;
  assign out_req_ready = gnt & {NREQ{in_rst_n & can_accept}};
  assign out_rsp_valid = (state == FULL);

  genvar i;
  generate
    for (i = 0; i < NREQ; i++) begin : g_lane
      logic16_arb_lane #(.W(W)) u_lane (
        .gnt   (gnt[i]),
        .op    (in_req_op[2*i +: 2]),
        .a     (in_req_a[W*i +: W]),
        .b     (in_req_b[W*i +: W]),
        .sel   (in_req_sel[i]),
        .op_g  (op_g[i]),
        .a_g   (a_g[i]),
        .b_g   (b_g[i]),
        .sel_g (sel_g[i])
      );
    end
  endgenerate

  always_comb begin
    op_m  = '0;
    a_m   = '0;
    b_m   = '0;
    for (int k = 0; k < NREQ; k++) begin
      op_m = op_m | op_g[k];
      a_m  = a_m  | a_g[k];
      b_m  = b_m  | b_g[k];
    end
    sel_m = |sel_g;
  end

  logic16_lu #(.W(W)) u_lu (
    .op  (op_m),
    .a   (a_m),
    .b   (b_m),
    .sel (sel_m),
    .y   (lu_y)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req_xfer) state_nxt = FULL;
      FULL: if (req_xfer) state_nxt = FULL;
            else if (in_rsp_ready) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      state      <= IDLE;
      out_rsp_y  <= '0;
      out_rsp_id <= '0;
      out_count  <= '0;
      last_grant <= ID_W'(NREQ-1);
    end else begin
      state <= state_nxt;
      if (req_xfer) begin
        out_rsp_y  <= lu_y;
        out_rsp_id <= win_id;
        last_grant <= win_id;
      end
      if (rsp_xfer) out_count <= out_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_logic16_arbiter.sv
// Randomized + directed bench for logic16_arbiter against a cycle-level scan model.

module tb_logic16_arbiter;
  localparam int NREQ = 4;
  localparam int W    = 16;
  localparam int ID_W = 2;

  logic                in_clk = 1'b0;
  logic                in_rst_n = 1'b0;
  logic [NREQ-1:0]     in_req_valid, out_req_ready;
  logic [2*NREQ-1:0]   in_req_op;
  logic [W*NREQ-1:0]   in_req_a, in_req_b;
  logic [NREQ-1:0]     in_req_sel;
  logic                out_rsp_valid;
  logic                in_rsp_ready = 1'b0;
  logic [W-1:0]        out_rsp_y;
  logic [ID_W-1:0]     out_rsp_id;
  logic [15:0]         out_count;

  always #5 in_clk = ~in_clk;

  logic [NREQ-1:0] v = '0;
  logic [1:0]      r_op [NREQ];
  logic [W-1:0]    r_a  [NREQ];
  logic [W-1:0]    r_b  [NREQ];
  logic [NREQ-1:0] r_sel = '0;

  always_comb begin
    in_req_valid = v;
    in_req_sel   = r_sel;
    in_req_op    = '0;
    in_req_a     = '0;
    in_req_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      in_req_op[2*i +: 2] = r_op[i];
      in_req_a[W*i +: W]  = r_a[i];
      in_req_b[W*i +: W]  = r_b[i];
    end
  end

  logic16_arbiter #(.NREQ(NREQ), .W(W), .ID_W(ID_W)) dut (
    .in_clk        (in_clk),
    .in_rst_n      (in_rst_n),
    .in_req_valid  (in_req_valid),
    .out_req_ready (out_req_ready),
    .in_req_op     (in_req_op),
    .in_req_a      (in_req_a),
    .in_req_b      (in_req_b),
    .in_req_sel    (in_req_sel),
    .out_rsp_valid (out_rsp_valid),
    .in_rsp_ready  (in_rsp_ready),
    .out_rsp_y     (out_rsp_y),
    .out_rsp_id    (out_rsp_id),
    .out_count     (out_count)
  );

  // Reference model state
  bit          m_full;
  logic [15:0] m_y, m_cnt;
  int          m_id, m_last;
  int          rnd_mode;   // 0 directed, 1 random, 2 saturating
  int          n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h @%0t", tag, obs, exp, $time);
  endtask

  function automatic logic [15:0] lu(input logic [1:0] op, input logic [15:0] a,
                                     input logic [15:0] b, input logic sel);
    case (op)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return sel ? b : a;
    endcase
  endfunction

  function automatic int pick();
    for (int k = 1; k <= NREQ; k++) begin
      int j = (m_last + k) % NREQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  task automatic rand_req(input int i);
    r_op[i]  = 2'($urandom_range(3));
    r_a[i]   = 16'($urandom);
    r_b[i]   = 16'($urandom);
    r_sel[i] = 1'($urandom_range(1));
  endtask

  task automatic model_reset();
    m_full = 0; m_y = '0; m_id = 0; m_cnt = '0; m_last = NREQ-1;
  endtask

  // One cycle: check outputs at negedge, advance model on posedge, update requesters.
  task automatic step();
    int w;
    logic [NREQ-1:0] er;
    bit rx;
    @(negedge in_clk);
    w  = pick();
    er = '0;
    if (w >= 0 && (!m_full || in_rsp_ready)) er = NREQ'(1) << w;
    chk("ready",     32'(out_req_ready), 32'(er));
    chk("rsp_valid", 32'(out_rsp_valid), 32'(m_full));
    chk("rsp_y",     32'(out_rsp_y),     32'(m_y));
    chk("rsp_id",    32'(out_rsp_id),    32'(m_id));
    chk("count",     32'(out_count),     32'(m_cnt));
    @(posedge in_clk);
    rx = m_full && in_rsp_ready;
    if (rx) m_cnt++;
    if (er != 0) begin
      m_y = lu(r_op[w], r_a[w], r_b[w], r_sel[w]);
      m_id = w; m_last = w; m_full = 1;
    end else if (rx) m_full = 0;
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (er[i]) begin
        if (rnd_mode == 0) v[i] = 1'b0;
        else begin
          v[i] = (rnd_mode == 2) ? 1'b1 : ($urandom_range(3) != 0);
          rand_req(i);
        end
      end else if (rnd_mode == 1) begin
        if (!v[i] && $urandom_range(2) == 0) begin v[i] = 1'b1; rand_req(i); end
        else if (v[i] && $urandom_range(15) == 0) v[i] = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    in_rst_n = 1'b0;
    v = '1;
    #1;
    chk("rst_ready", 32'(out_req_ready), 32'h0);
    chk("rst_valid", 32'(out_rsp_valid), 32'h0);
    chk("rst_count", 32'(out_count),     32'h0);
    chk("rst_y",     32'(out_rsp_y),     32'h0);
    chk("rst_id",    32'(out_rsp_id),    32'h0);
    model_reset();
    @(posedge in_clk); #1;
    in_rst_n = 1'b1;
    v = '0;
    in_rsp_ready = 1'b0;
    rnd_mode = 0;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    model_reset();
    rnd_mode = 0;

    // Single AND request, immediate consume
    do_reset();
    in_rsp_ready = 1'b1;
    v[0] = 1'b1; r_op[0] = 2'b01; r_a[0] = 16'hF0F0; r_b[0] = 16'hFF00; r_sel[0] = 1'b0;
    #1 chk("t1_ready", 32'(out_req_ready), 32'h1);
    step();
    chk("t1_valid", 32'(out_rsp_valid), 32'h1);
    chk("t1_y",     32'(out_rsp_y),     32'hF000);
    chk("t1_id",    32'(out_rsp_id),    32'h0);
    step();
    chk("t1_count", 32'(out_count), 32'h1);

    // Round robin with all requesters busy
    do_reset();
    in_rsp_ready = 1'b1; rnd_mode = 2;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    v = '1;
    for (int r = 0; r < 5; r++) begin
      step();
      chk("rr_id", 32'(out_rsp_id), 32'(r % NREQ));
      chk("rr_valid", 32'(out_rsp_valid), 32'h1);
    end
    step();
    chk("rr_count", 32'(out_count), 32'h5);

    // MUX under backpressure
    do_reset();
    v[2] = 1'b1; r_op[2] = 2'b11; r_sel[2] = 1'b1; r_a[2] = 16'h1234; r_b[2] = 16'hABCD;
    step();
    v[0] = 1'b1; rand_req(0);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_y",     32'(out_rsp_y),     32'hABCD);
      chk("bp_id",    32'(out_rsp_id),    32'h2);
      chk("bp_ready", 32'(out_req_ready), 32'h0);
      chk("bp_count", 32'(out_count),     32'h0);
    end
    in_rsp_ready = 1'b1;
    #1 chk("bp_release", 32'(out_req_ready), 32'h1);
    step();
    chk("bp_count1", 32'(out_count),  32'h1);
    chk("bp_next",   32'(out_rsp_id), 32'h0);

    // NOT and OR
    do_reset();
    in_rsp_ready = 1'b1;
    v[1] = 1'b1; r_op[1] = 2'b00; r_a[1] = 16'h00FF; r_b[1] = 16'($urandom);
    step();
    chk("not_y",  32'(out_rsp_y),  32'hFF00);
    chk("not_id", 32'(out_rsp_id), 32'h1);
    v[3] = 1'b1; r_op[3] = 2'b10; r_a[3] = 16'h0F00; r_b[3] = 16'h00F0;
    step();
    chk("or_y",  32'(out_rsp_y),  32'h0FF0);
    chk("or_id", 32'(out_rsp_id), 32'h3);

    // Random traffic with random backpressure
    do_reset();
    rnd_mode = 1;
    repeat (400) begin
      in_rsp_ready = ($urandom_range(3) != 0);
      step();
    end

    // Reset while holding a result
    rnd_mode = 0; v = '0; in_rsp_ready = 1'b0;
    v[0] = 1'b1; rand_req(0);
    step();
    chk("t5_full", 32'(out_rsp_valid), 32'h1);
    #2;
    do_reset();
    v[0] = 1'b1; v[3] = 1'b1; rand_req(0); rand_req(3);
    in_rsp_ready = 1'b1;
    #1 chk("t5_prio", 32'(out_req_ready), 32'h1);
    step();
    chk("t5_first", 32'(out_rsp_id), 32'h0);
    step();
    chk("t5_second", 32'(out_rsp_id), 32'h3);

    // Response counter wrap
    do_reset();
    rnd_mode = 2; in_rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) rand_req(i);
    v = '1;
    guard = 0;
    while (m_cnt != 16'hFFFF && guard < 70000) begin
      step();
      guard++;
    end
    chk("pre_wrap", 32'(out_count), 32'hFFFF);
    step();
    chk("wrap", 32'(out_count), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
